// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int STAT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority picker: first set request at or above ptr, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [PW-1:0]      winner,
    output logic               any
);

    logic [PW:0] pos;

    // Scan from the farthest offset down so the nearest requester above ptr wins.
    always_comb begin
        winner = '0;
        any    = |req;
        pos    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            pos = {1'b0, ptr} + (PW+1)'(i);
            if (pos >= (PW+1)'(NUM_REQ)) begin
                pos = pos - (PW+1)'(NUM_REQ);
            end
            if (req[pos[PW-1:0]]) begin
                winner = pos[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port between NUM_REQ producers.
// Optional FIFO_ARB_STATS_EN adds saturating beat and stall counters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]           fifo_wdata,
    output logic                       fifo_wen,
    input  logic                       fifo_full,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]  stat_beats,
    output logic [STAT_W-1:0]          stat_stalls
`endif
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t    state, state_nxt;
    logic [PW-1:0] grant_nxt;
    logic [PW-1:0] rr_ptr, ptr_nxt;
    logic [CW-1:0] beat_cnt, cnt_nxt;
    logic [PW-1:0] winner;
    logic          any_req;
    logic [PW-1:0] ptr_after_grant;
    logic          granted_valid;
    logic          granted_last;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr_pick (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .winner (winner),
        .any    (any_req)
    );

    assign ptr_after_grant = (grant_id == PW'(NUM_REQ - 1)) ? '0 : grant_id + PW'(1);
    assign granted_valid   = req_valid[grant_id];
    assign granted_last    = req_last[grant_id];

    // Reset overrides every output so nothing is acknowledged or written in the reset cycle.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant_id;
        ptr_nxt     = rr_ptr;
        cnt_nxt     = beat_cnt;
        req_ready   = '0;
        fifo_wen    = 1'b0;
        fifo_wdata  = '0;
        grant_valid = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state_nxt = BURST;
                        grant_nxt = winner;
                        cnt_nxt   = '0;
                    end
                end
                BURST: begin
                    grant_valid         = 1'b1;
                    req_ready[grant_id] = !fifo_full;
                    fifo_wen            = granted_valid && !fifo_full;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant_id == PW'(i)) begin
                            fifo_wdata = req_data[i*WIDTH +: WIDTH];
                        end
                    end
                    if (!granted_valid) begin
                        state_nxt = IDLE;
                        ptr_nxt   = ptr_after_grant;
                    end else if (!fifo_full) begin
                        cnt_nxt = beat_cnt + CW'(1);
                        if (granted_last || beat_cnt == CW'(MAX_BURST - 1)) begin
                            state_nxt = IDLE;
                            ptr_nxt   = ptr_after_grant;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            rr_ptr   <= ptr_nxt;
            beat_cnt <= cnt_nxt;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_W-1:0] beats_q [NUM_REQ];
    logic [STAT_W-1:0] stalls_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                beats_q[i] <= '0;
            end
            stalls_q <= '0;
        end else begin
            if (fifo_wen && beats_q[grant_id] != '1) begin
                beats_q[grant_id] <= beats_q[grant_id] + STAT_W'(1);
            end
            if (grant_valid && granted_valid && fifo_full && stalls_q != '1) begin
                stalls_q <= stalls_q + STAT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_beats[g*STAT_W +: STAT_W] = beats_q[g];
    end
    assign stat_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic [7:0]  fifo_wdata;
    logic        fifo_wen, fifo_full, grant_valid;
    logic [1:0]  grant_id;
`ifdef FIFO_ARB_STATS_EN
    logic [4*STAT_W-1:0] stat_beats;
    logic [STAT_W-1:0]   stat_stalls;
`endif

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_wdata  (fifo_wdata),
        .fifo_wen    (fifo_wen),
        .fifo_full   (fifo_full),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_beats  (stat_beats),
        .stat_stalls (stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: who owns the port, beats taken, where the rotation resumes.
    bit   m_busy = 0;
    int   m_gid = 0, m_ptr = 0, m_cnt = 0, m_idx;
    int   m_beats[4] = '{0, 0, 0, 0};
    int   m_stalls = 0;
    bit   m_found;
    int   exp_log[$];
    logic [3:0] e_ready;
    logic [7:0] e_wdata;
    logic       e_wen, e_gv;

    always @(negedge clk) begin
        e_ready = '0; e_wen = 0; e_wdata = '0; e_gv = 0;
        if (!rst && m_busy) begin
            e_gv    = 1;
            e_ready = fifo_full ? 4'b0 : 4'(1 << m_gid);
            e_wen   = req_valid[m_gid] && !fifo_full;
            e_wdata = 8'(req_data >> (8 * m_gid));
        end
        checkOutput("req_ready", req_ready, e_ready);
        checkOutput("fifo_wen", fifo_wen, e_wen);
        checkOutput("fifo_wdata", fifo_wdata, e_wdata);
        checkOutput("grant_valid", grant_valid, e_gv);
        checkOutput("grant_id", grant_id, m_gid);
`ifdef FIFO_ARB_STATS_EN
        for (int i = 0; i < 4; i++) checkOutput("stat_beats", stat_beats[i*16 +: 16], m_beats[i]);
        checkOutput("stat_stalls", stat_stalls, m_stalls);
`endif
        if (rst) begin
            m_busy = 0; m_gid = 0; m_ptr = 0; m_cnt = 0; m_stalls = 0;
            for (int i = 0; i < 4; i++) m_beats[i] = 0;
        end else if (!m_busy) begin
            m_found = 0;
            for (int k = 0; k < 4; k++) begin
                m_idx = (m_ptr + k) % 4;
                if (!m_found && req_valid[m_idx]) begin
                    m_found = 1;
                    m_gid   = m_idx;
                end
            end
            if (m_found) begin
                m_busy = 1;
                m_cnt  = 0;
            end
        end else if (!req_valid[m_gid]) begin
            m_busy = 0;
            m_ptr  = (m_gid + 1) % 4;
        end else if (fifo_full) begin
            if (m_stalls < 65535) m_stalls++;
        end else begin
            exp_log.push_back(m_gid * 256 + int'(e_wdata));
            if (m_beats[m_gid] < 65535) m_beats[m_gid]++;
            m_cnt++;
            if (req_last[m_gid] || m_cnt == MAX_BURST) begin
                m_busy = 0;
                m_ptr  = (m_gid + 1) % 4;
            end
        end
    end

    logic [3:0] tb_acc;
    logic       tb_wen;

    task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                                 input logic f, input logic r);
        req_valid = v; req_last = l; req_data = d; fifo_full = f; rst = r;
        @(negedge clk);
        tb_acc = req_valid & req_ready;
        tb_wen = fifo_wen;
        @(posedge clk);
        #1;
    endtask

    task automatic checkLog(input string name, input int idx, input int expected);
        if (idx < exp_log.size()) begin
            checkOutput(name, exp_log[idx], expected);
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: write %0d missing, expected 0x%0h", name, idx, expected);
        end
    endtask

    int n1, n2;
    bit r3done;
    logic [3:0] v, l;
    logic [7:0] dd;
    logic f;

    initial begin
        req_valid = '0; req_last = '0; req_data = '0; fifo_full = 0; rst = 1;

        $display("[TB] reset then idle");
        repeat (2) applyStimulus(4'h0, 4'h0, 32'h0, 0, 1);
        checkOutput("reset_ready", req_ready, 0);
        checkOutput("reset_wen", fifo_wen, 0);
        checkOutput("reset_grant_valid", grant_valid, 0);
        checkOutput("reset_grant_id", grant_id, 0);
        repeat (2) applyStimulus(4'h0, 4'h0, 32'h0, 0, 0);
        checkOutput("idle_grant_valid", grant_valid, 0);
        checkOutput("idle_ready", req_ready, 0);

        $display("[TB] round-robin fairness");
        exp_log.delete();
        repeat (10) applyStimulus(4'hF, 4'hF, 32'hA3A2A1A0, 0, 0);
        checkOutput("fair_writes", exp_log.size(), 5);
        checkLog("fair_0", 0, 32'h0A0);
        checkLog("fair_1", 1, 32'h1A1);
        checkLog("fair_2", 2, 32'h2A2);
        checkLog("fair_3", 3, 32'h3A3);
        checkLog("fair_4", 4, 32'h0A0);
        applyStimulus(4'h0, 4'h0, 32'h0, 0, 1);

        $display("[TB] burst cap");
        exp_log.delete();
        n2 = 0; r3done = 0;
        for (int c = 0; c < 14; c++) begin
            v  = {!r3done, n2 < 6, 2'b00};
            dd = 8'h10 + 8'(n2);
            applyStimulus(v, 4'b1000, {8'h33, dd, 16'h0}, 0, 0);
            if (tb_acc[2]) n2++;
            if (tb_acc[3]) r3done = 1;
        end
        checkLog("cap_0", 0, 32'h210);
        checkLog("cap_1", 1, 32'h211);
        checkLog("cap_2", 2, 32'h212);
        checkLog("cap_3", 3, 32'h213);
        checkLog("cap_other", 4, 32'h333);
        checkLog("cap_resume", 5, 32'h214);
        checkLog("cap_6", 6, 32'h215);
        applyStimulus(4'h0, 4'h0, 32'h0, 0, 1);

        $display("[TB] full stall");
        exp_log.delete();
        n1 = 0;
        for (int c = 0; c < 12; c++) begin
            v  = (n1 < 4) ? 4'b0010 : 4'b0000;
            l  = (n1 == 3) ? 4'b0010 : 4'b0000;
            dd = 8'h40 + 8'(n1);
            f  = (c >= 2 && c <= 4);
            applyStimulus(v, l, {16'h0, dd, 8'h0}, f, 0);
            if (f) checkOutput("stall_no_accept", {tb_wen, tb_acc}, 0);
            if (tb_acc[1]) n1++;
        end
        checkOutput("stall_writes", exp_log.size(), 4);
        checkLog("stall_0", 0, 32'h140);
        checkLog("stall_1", 1, 32'h141);
        checkLog("stall_2", 2, 32'h142);
        checkLog("stall_3", 3, 32'h143);
        checkOutput("model_stalls", m_stalls, 3);
`ifdef FIFO_ARB_STATS_EN
        checkOutput("stat_stalls_lit", stat_stalls, 3);
        checkOutput("stat_beats1_lit", stat_beats[16 +: 16], 4);
`endif
        applyStimulus(4'h0, 4'h0, 32'h0, 0, 1);

        $display("[TB] abandon");
        exp_log.delete();
        repeat (2) applyStimulus(4'b0001, 4'b0000, 32'h00000055, 0, 0);
        applyStimulus(4'b0000, 4'b0000, 32'h0, 0, 0);
        applyStimulus(4'b0011, 4'b0011, 32'h00006655, 0, 0);
        checkOutput("abandon_next_gid", grant_id, 1);
        checkOutput("abandon_next_gv", grant_valid, 1);
        applyStimulus(4'b0011, 4'b0011, 32'h00006655, 0, 0);
        applyStimulus(4'b0000, 4'b0000, 32'h0, 0, 0);
        checkLog("abandon_0", 0, 32'h055);
        checkLog("abandon_1", 1, 32'h166);

        $display("[TB] reset mid-burst");
        exp_log.delete();
        repeat (2) applyStimulus(4'b0100, 4'b0000, 32'h00770000, 0, 0);
        applyStimulus(4'b0100, 4'b0000, 32'h00770000, 0, 1);
        checkOutput("rst_no_wen", {tb_wen, tb_acc}, 0);
        applyStimulus(4'b0101, 4'b0101, 32'h00770088, 0, 0);
        checkOutput("rst_next_gid", grant_id, 0);
        applyStimulus(4'b0101, 4'b0101, 32'h00770088, 0, 0);
        checkLog("rst_0", 0, 32'h277);
        checkLog("rst_1", 1, 32'h088);

        $display("[TB] random traffic");
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 4; i++) l[i] = ($urandom_range(0, 9) < 3);
            applyStimulus(4'($urandom), l, $urandom, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 99) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
